btb_set_assoc: RTL

BTB_SET_ASSOC -- requirements
Module: btb_set_assoc

---
 rtl/btb_set_assoc.sv | 108 ++++++++++
 1 files changed

// File: rtl/btb_set_assoc.sv
// btb_set_assoc: set-associative branch target buffer with registered lookup and round-robin replacement
module btb_set_assoc #(
  parameter int XLEN  = 32,
  parameter int SETS  = 64,
  parameter int WAYS  = 4,
  parameter int CTR_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lk_valid,
  input  logic [XLEN-1:0] lk_pc,
  output logic            pred_valid,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_taken,
  input  logic            flush
);
  localparam int IDX = $clog2(SETS);
  localparam int TW  = XLEN - IDX - 2;
  localparam int WW  = (WAYS > 1) ? $clog2(WAYS) : 1;
  logic             valid_q [SETS][WAYS];
  logic [TW-1:0]    tag_q   [SETS][WAYS];
  logic [XLEN-1:0]  tgt_q   [SETS][WAYS];
  logic [CTR_W-1:0] ctr_q   [SETS][WAYS];
  logic [WW-1:0]    ptr_q   [SETS];
  logic             pred_valid_q, pred_hit_q, pred_taken_q;
  logic [XLEN-1:0]  pred_target_q;
  logic [IDX-1:0]   lk_idx, up_idx;
  logic [TW-1:0]    lk_tag, up_tag;
  logic             lk_hit, up_hit, up_inv;
  logic [WW-1:0]    lk_way, up_way, inv_way, wr_way, ptr_d;
  logic [CTR_W-1:0] up_ctr, ctr_d;
  assign lk_idx = lk_pc[IDX+1:2];
  assign lk_tag = lk_pc[XLEN-1:IDX+2];
  assign up_idx = upd_pc[IDX+1:2];
  assign up_tag = upd_pc[XLEN-1:IDX+2];
  // Descending scans leave the lowest-numbered matching way selected
  always_comb begin
    lk_hit  = 1'b0;
    lk_way  = '0;
    up_hit  = 1'b0;
    up_way  = '0;
    up_inv  = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[lk_idx][w] && tag_q[lk_idx][w] == lk_tag) begin
        lk_hit = 1'b1;
        lk_way = WW'(w);
      end
      if (valid_q[up_idx][w] && tag_q[up_idx][w] == up_tag) begin
        up_hit = 1'b1;
        up_way = WW'(w);
      end
      if (!valid_q[up_idx][w]) begin
        up_inv  = 1'b1;
        inv_way = WW'(w);
      end
    end
  end
  assign up_ctr = ctr_q[up_idx][up_way];
  assign ctr_d  = upd_taken ? ((&up_ctr) ? up_ctr : up_ctr + 1'b1)
                            : ((|up_ctr) ? up_ctr - 1'b1 : up_ctr);
  assign ptr_d  = (ptr_q[up_idx] == WW'(WAYS - 1)) ? '0 : ptr_q[up_idx] + 1'b1;
  assign wr_way = up_inv ? inv_way : ptr_q[up_idx];
  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid_q  <= 1'b0;
      pred_hit_q    <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        ptr_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          ctr_q[s][w]   <= '0;
        end
      end
    end else begin
      pred_valid_q  <= lk_valid;
      pred_hit_q    <= lk_valid && lk_hit;
      pred_taken_q  <= lk_valid && lk_hit && ctr_q[lk_idx][lk_way][CTR_W-1];
      pred_target_q <= (lk_valid && lk_hit) ? tgt_q[lk_idx][lk_way] : '0;
      if (flush) begin
        for (int s = 0; s < SETS; s++) begin
          ptr_q[s] <= '0;
          for (int w = 0; w < WAYS; w++) valid_q[s][w] <= 1'b0;
        end
      end else if (upd_valid && up_hit) begin
        ctr_q[up_idx][up_way] <= ctr_d;
        if (upd_taken) tgt_q[up_idx][up_way] <= upd_target;
      end else if (upd_valid && upd_taken) begin
        valid_q[up_idx][wr_way] <= 1'b1;
        tag_q[up_idx][wr_way]   <= up_tag;
        tgt_q[up_idx][wr_way]   <= upd_target;
        ctr_q[up_idx][wr_way]   <= CTR_W'(1 << (CTR_W - 1));
        if (!up_inv) ptr_q[up_idx] <= ptr_d;
      end
    end
  end
  assign pred_valid  = pred_valid_q;
  assign pred_hit    = pred_hit_q;
  assign pred_taken  = pred_taken_q;
  assign pred_target = pred_target_q;
endmodule
